pattern_seq_checker: RTL

//  Parametrised checker for a repeated multi-byte pattern on a valid-qualified byte stream.

---
 rtl/pattern_seq_checker_pkg.sv | 16 +
 rtl/pattern_seq_checker_matcher.sv | 57 +++++
 rtl/pattern_seq_checker.sv | 92 +++++++++
 3 files changed

// File: rtl/pattern_seq_checker_pkg.sv
// Shared types and helpers for the repeated-pattern stream checker.
package pattern_seq_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHunt,
    StLock,
    StDone
  } pchk_state_t;

  // LSB position of symbol k inside a packed pattern word; symbol 0 is sent first.
  function automatic int unsigned sym_lsb(input int unsigned k, input int unsigned sym_w);
    return k * sym_w;
  endfunction

endpackage

// File: rtl/pattern_seq_checker_matcher.sv
// Holds the position within the pattern word and compares the incoming symbol against it.
module pattern_seq_checker_matcher
  import pattern_seq_checker_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PAT_BYTES = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        clear,
  input  logic                        advance,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [PAT_BYTES*DATA_W-1:0] pat_q,
  output logic                        match,
  output logic                        word_done
);

  localparam int unsigned IDX_W = $clog2(PAT_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_BYTES - 1);

  logic [DATA_W-1:0] syms [PAT_BYTES];
  logic [IDX_W-1:0]  idx_d, idx_q;

  for (genvar k = 0; k < PAT_BYTES; k++) begin : g_sym
    assign syms[k] = pat_q[sym_lsb(k, DATA_W) +: DATA_W];
  end

  assign match     = (data_in == syms[idx_q]);
  assign word_done = match && (idx_q == LAST_IDX);

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (advance) begin
      if (word_done) begin
        idx_d = '0;
      end else if (match) begin
        idx_d = idx_q + 1'b1;
      end else if (data_in == syms[0]) begin
        // The offending symbol may itself start a fresh word.
        idx_d = IDX_W'(1);
      end else begin
        idx_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/pattern_seq_checker.sv
// Link-test pattern checker: hunts for word alignment, counts back-to-back repetitions,
// flags pass after N of them and counts symbol errors once lock has been reached.
module pattern_seq_checker
  import pattern_seq_checker_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PAT_BYTES = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_W     = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        data_valid,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [PAT_BYTES*DATA_W-1:0] pattern,
  input  logic [CNT_W-1:0]            N,
  input  logic                        check_start,
  output logic                        pattern_correct,
  output logic                        locked,
  output logic [CNT_W-1:0]            rep_count,
  output logic [ERR_W-1:0]            err_count
);

  pchk_state_t                 state_q;
  logic [PAT_BYTES*DATA_W-1:0] pat_q;
  logic [CNT_W-1:0]            n_q;
  logic [CNT_W-1:0]            rep_inc;
  logic                        match, word_done, advance;

  // check_start wins over a symbol arriving in the same cycle.
  assign advance = data_valid && !check_start && ((state_q == StHunt) || (state_q == StLock));
  assign rep_inc = rep_count + 1'b1;

  pattern_seq_checker_matcher #(
    .DATA_W   (DATA_W),
    .PAT_BYTES(PAT_BYTES)
  ) u_matcher (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (check_start),
    .advance  (advance),
    .data_in  (data_in),
    .pat_q    (pat_q),
    .match    (match),
    .word_done(word_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q         <= StIdle;
      pat_q           <= '0;
      n_q             <= '0;
      pattern_correct <= 1'b0;
      locked          <= 1'b0;
      rep_count       <= '0;
      err_count       <= '0;
    end else if (check_start) begin
      state_q         <= StHunt;
      pat_q           <= pattern;
      n_q             <= (N == '0) ? CNT_W'(1) : N;
      pattern_correct <= 1'b0;
      locked          <= 1'b0;
      rep_count       <= '0;
      err_count       <= '0;
    end else if (advance) begin
      unique case (state_q)
        StHunt, StLock: begin
          if (word_done) begin
            rep_count <= rep_inc;
            if (rep_inc == n_q) begin
              state_q         <= StDone;
              pattern_correct <= 1'b1;
              locked          <= 1'b0;
            end else begin
              state_q <= StLock;
              locked  <= 1'b1;
            end
          end else if (!match && (state_q == StLock)) begin
            state_q   <= StHunt;
            locked    <= 1'b0;
            rep_count <= '0;
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
